// File: rtl/fifo_dat_serializer_if.sv
// Bundles the serializer's control, FIFO-side and SD DAT0-side signals.
// The master is the host that drives start and the FIFO; the slave is the serializer.
interface fifo_dat_serializer_if;
  logic        start;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        dat_out;
  logic        dat_oe;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output start, fifo_data, fifo_empty,
    input  fifo_read, dat_out, dat_oe, busy, stall, done
  );

  modport slave (
    input  start, fifo_data, fifo_empty,
    output fifo_read, dat_out, dat_oe, busy, stall, done
  );
endinterface

// File: rtl/fifo_dat_serializer.sv
// Serialises one block of WORDS 32-bit FIFO words onto SD DAT0:
// start bit, MSB-first data, CRC16-CCITT, end bit; freezes (stall) when the FIFO runs dry.
module fifo_dat_serializer #(
  parameter int unsigned WORDS = 128
) (
  input logic               clock,
  input logic               reset,
  fifo_dat_serializer_if.slave bus
);

  localparam int unsigned     WCW       = $clog2(WORDS) + 1;
  localparam logic [15:0]     CRC_POLY  = 16'h1021;
  localparam logic [WCW-1:0]  LAST_WORD = WCW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_WAIT, S_CRC, S_END
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     shreg, shreg_nx;
  logic [15:0]     crc, crc_nx, crc_upd;
  logic [4:0]      bit_cnt, bit_cnt_nx;
  logic [WCW-1:0]  word_cnt, word_cnt_nx;
  logic            pref, pref_nx;
  logic            dat_out_q, dat_out_nx;
  logic            dat_oe_q, dat_oe_nx;
  logic            busy_q, busy_nx;
  logic            stall_q, stall_nx;
  logic            done_q, done_nx;
  logic            rd;
  logic            last_word;
  logic            fb;

  assign last_word = (word_cnt == LAST_WORD);
  // shreg[31] is always the bit currently on the line during DATA
  assign fb        = crc[15] ^ shreg[31];
  assign crc_upd   = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      crc       <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      pref      <= 1'b0;
      dat_out_q <= 1'b1;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      stall_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      crc       <= crc_nx;
      bit_cnt   <= bit_cnt_nx;
      word_cnt  <= word_cnt_nx;
      pref      <= pref_nx;
      dat_out_q <= dat_out_nx;
      dat_oe_q  <= dat_oe_nx;
      busy_q    <= busy_nx;
      stall_q   <= stall_nx;
      done_q    <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    crc_nx      = crc;
    bit_cnt_nx  = bit_cnt;
    word_cnt_nx = word_cnt;
    pref_nx     = pref;
    dat_out_nx  = dat_out_q;
    rd          = 1'b0;

    case (state)
      S_IDLE: begin
        dat_out_nx = 1'b1;
        if (bus.start) begin
          state_nx    = S_FETCH;
          crc_nx      = '0;
          word_cnt_nx = '0;
          pref_nx     = 1'b0;
        end
      end
      S_FETCH: begin
        dat_out_nx = 1'b1;
        if (!bus.fifo_empty) begin
          rd         = 1'b1;
          state_nx   = S_START;
          dat_out_nx = 1'b0;
        end
      end
      S_START: begin
        shreg_nx   = bus.fifo_data;
        dat_out_nx = bus.fifo_data[31];
        bit_cnt_nx = 5'd31;
        state_nx   = S_DATA;
      end
      S_DATA: begin
        crc_nx = crc_upd;
        // Prefetch the next word one bit early so it lands exactly after bit 0
        if (bit_cnt == 5'd1 && !last_word && !bus.fifo_empty) begin
          rd      = 1'b1;
          pref_nx = 1'b1;
        end
        if (bit_cnt != 5'd0) begin
          shreg_nx   = {shreg[30:0], 1'b0};
          dat_out_nx = shreg[30];
          bit_cnt_nx = bit_cnt - 5'd1;
        end else begin
          word_cnt_nx = word_cnt + WCW'(1);
          if (last_word) begin
            state_nx   = S_CRC;
            bit_cnt_nx = 5'd15;
            dat_out_nx = crc_upd[15];
          end else if (pref) begin
            pref_nx    = 1'b0;
            shreg_nx   = bus.fifo_data;
            dat_out_nx = bus.fifo_data[31];
            bit_cnt_nx = 5'd31;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (pref) begin
          pref_nx    = 1'b0;
          shreg_nx   = bus.fifo_data;
          dat_out_nx = bus.fifo_data[31];
          bit_cnt_nx = 5'd31;
          state_nx   = S_DATA;
        end else if (!bus.fifo_empty) begin
          rd      = 1'b1;
          pref_nx = 1'b1;
        end
      end
      S_CRC: begin
        crc_nx     = {crc[14:0], 1'b0};
        dat_out_nx = crc[14];
        bit_cnt_nx = bit_cnt - 5'd1;
        if (bit_cnt == 5'd0) begin
          state_nx   = S_END;
          dat_out_nx = 1'b1;
        end
      end
      S_END: begin
        state_nx   = S_IDLE;
        dat_out_nx = 1'b1;
      end
      default: begin
        state_nx   = S_IDLE;
        dat_out_nx = 1'b1;
      end
    endcase

    busy_nx   = (state_nx != S_IDLE);
    dat_oe_nx = (state_nx != S_IDLE) && (state_nx != S_FETCH);
    stall_nx  = (state_nx == S_WAIT);
    done_nx   = (state == S_END);
  end

  // Pop request is decoded so the FIFO word arrives on the following cycle
  assign bus.fifo_read = rd & reset;
  assign bus.dat_out   = dat_out_q;
  assign bus.dat_oe    = dat_oe_q;
  assign bus.busy      = busy_q;
  assign bus.stall     = stall_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fifo_dat_serializer.sv
// Scoreboard bench: one serializer with WORDS=1 and one with WORDS=2, fed from queue-modelled FIFOs.
module tb_fifo_dat_serializer;

  localparam int N_INST = 2;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_last;
  logic        start_s [N_INST];
  logic        empty_s [N_INST];
  logic [31:0] data_s  [N_INST];
  logic        rd_s    [N_INST];
  logic        dout_s  [N_INST];
  logic        oe_s    [N_INST];
  logic        busy_s  [N_INST];
  logic        stall_s [N_INST];
  logic        done_s  [N_INST];

  logic [31:0] fifo_q [N_INST][$];
  bit          exp_q  [N_INST][$];
  int unsigned blk_q  [N_INST][$];
  int          exp_done [N_INST];

  int          rd_cnt    [N_INST];
  int          bits_cnt  [N_INST];
  int          oe_run    [N_INST];
  int          stall_run [N_INST];
  int          done_cnt  [N_INST];
  logic        last_bit  [N_INST];
  logic        oe_prev   [N_INST];

  int n_cmp = 0;
  int n_bad = 0;
  bit final_req = 1'b0;
  bit final_ack = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    fifo_dat_serializer_if u_if ();
    assign u_if.start      = start_s[g];
    assign u_if.fifo_data  = data_s[g];
    assign u_if.fifo_empty = empty_s[g];
    assign rd_s[g]    = u_if.fifo_read;
    assign dout_s[g]  = u_if.dat_out;
    assign oe_s[g]    = u_if.dat_oe;
    assign busy_s[g]  = u_if.busy;
    assign stall_s[g] = u_if.stall;
    assign done_s[g]  = u_if.done;
    fifo_dat_serializer #(.WORDS(g + 1)) u_dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (u_if)
    );
  end

  // FIFO model: read data appears the cycle after a pop
  always @(posedge clk) begin
    rst_last <= rst_n;
    for (int i = 0; i < N_INST; i++) begin
      if (rd_s[i] && fifo_q[i].size() != 0) data_s[i] <= fifo_q[i].pop_front();
      empty_s[i] <= (fifo_q[i].size() == 0);
    end
  end

  function automatic void check(input string name, input int inst, input longint act, input longint exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s[inst %0d] @%0t: got %0d, expected %0d", name, inst, $time, act, exp_v);
    end
  endfunction

  // CRC16-CCITT as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] crc16_div(input bit msg [$]);
    bit          a [$];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    a = msg;
    repeat (16) a.push_back(1'b0);
    for (int n = 0; n < msg.size(); n++)
      if (a[n]) for (int j = 0; j <= 16; j++) a[n + j] ^= g[16 - j];
    for (int j = 0; j < 16; j++) r[15 - j] = a[msg.size() + j];
    return r;
  endfunction

  function automatic void push_stream(input int i, input logic [31:0] words [$]);
    bit          msg [$];
    logic [15:0] c;
    for (int k = 0; k < words.size(); k++)
      for (int b = 31; b >= 0; b--) msg.push_back(words[k][b]);
    c = crc16_div(msg);
    exp_q[i].push_back(1'b0);
    foreach (msg[k]) exp_q[i].push_back(msg[k]);
    for (int b = 15; b >= 0; b--) exp_q[i].push_back(c[b]);
    exp_q[i].push_back(1'b1);
  endfunction

  // Monitor: every output check lives here, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N_INST; i++) begin
      if (!rst_last) begin
        check("reset_outputs", i,
              {58'd0, rd_s[i], dout_s[i], oe_s[i], busy_s[i], stall_s[i], done_s[i]}, 64'h10);
        exp_q[i].delete();
        blk_q[i].delete();
        rd_cnt[i] = 0; bits_cnt[i] = 0; oe_run[i] = 0; stall_run[i] = 0;
      end else begin
        if (oe_s[i]) begin
          oe_run[i]++;
          if (stall_s[i]) begin
            stall_run[i]++;
            check("stall_hold", i, dout_s[i], last_bit[i]);
          end else if (exp_q[i].size() == 0) begin
            check("extra_bit", i, 1, 0);
          end else begin
            bits_cnt[i]++;
            check("dat_out", i, dout_s[i], exp_q[i].pop_front());
          end
          last_bit[i] = dout_s[i];
        end else begin
          check("idle_line_high", i, dout_s[i], 1);
        end
        if (rd_s[i]) begin
          check("read_not_empty", i, empty_s[i], 0);
          check("read_in_block", i, (blk_q[i].size() != 0 && rd_cnt[i] < int'(blk_q[i][0])), 1);
          if (!stall_s[i] && rd_cnt[i] != 0) check("prefetch_slot", i, bits_cnt[i], 32 * rd_cnt[i]);
          rd_cnt[i]++;
        end
        if (oe_prev[i] && !oe_s[i]) check("end_then_done", i, done_s[i], 1);
        if (done_s[i]) begin
          if (blk_q[i].size() == 0) begin
            check("unexpected_done", i, 1, 0);
          end else begin
            int unsigned w;
            w = blk_q[i].pop_front();
            check("reads_per_block", i, rd_cnt[i], w);
            check("oe_cycles", i, oe_run[i] - stall_run[i], 32 * w + 18);
            check("stream_drained", i, exp_q[i].size(), 0);
          end
          done_cnt[i]++;
          rd_cnt[i] = 0; bits_cnt[i] = 0; oe_run[i] = 0; stall_run[i] = 0;
        end
      end
      oe_prev[i] = oe_s[i];
    end
    if (final_req && !final_ack) begin
      for (int i = 0; i < N_INST; i++) begin
        check("blocks_finished", i, blk_q[i].size(), 0);
        check("done_count", i, done_cnt[i], exp_done[i]);
      end
      final_ack = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int i, input logic [31:0] words [$]);
    push_stream(i, words);
    blk_q[i].push_back(words.size());
    exp_done[i]++;
    start_s[i] = 1'b1;
    tick(1);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < BUDGET; n++) begin
      if (!busy_s[i]) break;
      tick(1);
    end
    tick(2);
  endtask

  initial begin
    logic [31:0] wq [$];
    rst_n = 1'b0;
    for (int i = 0; i < N_INST; i++) begin
      start_s[i] = 1'b0; exp_done[i] = 0; done_cnt[i] = 0; oe_prev[i] = 1'b0;
      last_bit[i] = 1'b1; rd_cnt[i] = 0; bits_cnt[i] = 0; oe_run[i] = 0; stall_run[i] = 0;
    end
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // WORDS=1, all-zero word
    wq = '{32'h0000_0000};
    fifo_q[0].push_back(wq[0]);
    run_block(0, wq);
    wait_idle(0);

    // WORDS=2, back-to-back words with prefetch
    wq = '{32'h0FCB_CAFE, 32'h011C_AFEF};
    foreach (wq[k]) fifo_q[1].push_back(wq[k]);
    run_block(1, wq);
    wait_idle(1);

    // WORDS=2, FIFO runs dry at word-0 bit 1
    fifo_q[1].push_back(wq[0]);
    run_block(1, wq);
    for (int n = 0; n < BUDGET; n++) begin
      if (stall_s[1]) break;
      tick(1);
    end
    tick(4);
    fifo_q[1].push_back(wq[1]);
    wait_idle(1);

    // start pulsed during CRC with a spare word waiting must be ignored
    wq = '{$urandom(), $urandom()};
    foreach (wq[k]) fifo_q[1].push_back(wq[k]);
    run_block(1, wq);
    tick(70);
    fifo_q[1].push_back($urandom());
    start_s[1] = 1'b1;
    tick(1);
    start_s[1] = 1'b0;
    wait_idle(1);
    fifo_q[1].delete();
    tick(3);

    // reset mid-DATA: aborted block yields no done and no further reads
    wq = '{$urandom(), $urandom()};
    foreach (wq[k]) fifo_q[1].push_back(wq[k]);
    run_block(1, wq);
    tick(20);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_done[1]--;
    fifo_q[1].delete();
    tick(200);

    // random words, second word arriving after a random delay
    for (int n = 0; n < 10; n++) begin
      int inst;
      int dly;
      inst = n % 2;
      dly  = int'($urandom_range(0, 60));
      wq.delete();
      for (int k = 0; k <= inst; k++) wq.push_back($urandom());
      fifo_q[inst].push_back(wq[0]);
      run_block(inst, wq);
      if (inst == 1) begin
        tick(dly);
        fifo_q[1].push_back(wq[1]);
      end
      wait_idle(inst);
    end

    final_req = 1'b1;
    for (int n = 0; n < 10 && !final_ack; n++) tick(1);
    if (!final_ack) begin
      $display("FAIL final_check: not reached, got 0, expected 1");
      $fatal(1, "final check not reached");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_dat_serializer.md
FIFO_DAT_SERIALIZER -- requirements
Module: fifo_dat_serializer

Interface
REQ-001 SHALL have parameter WORDS, default 128, meaning 32-bit words per data block (legal range 1..1024).
REQ-002 SHALL have port clock  input  1  single clock for all logic, rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to transmit one block.
REQ-005 SHALL have port fifo_data  input  32  FIFO read data, valid the cycle after fifo_read.
REQ-006 SHALL have port fifo_empty  input  1  FIFO holds no words.
REQ-007 SHALL have port fifo_read  output  1  one-cycle pop request to the FIFO.
REQ-008 SHALL have port dat_out  output  1  serial SD DAT0 line value.
REQ-009 SHALL have port dat_oe  output  1  DAT0 output enable.
REQ-010 SHALL have port busy  output  1  block transfer in progress.
REQ-011 SHALL have port stall  output  1  waiting on FIFO mid-block; SD clock must be frozen.
REQ-012 SHALL have port done  output  1  one-cycle pulse, block complete.

Function
REQ-013 SHALL implement states IDLE, FETCH, START, DATA, WAIT, CRC, END.
REQ-014 IDLE: start=1 -> FETCH, busy=1 next cycle; start ignored in every other state.
REQ-015 FETCH: fifo_empty=0 -> fifo_read=1 for one cycle, go to START; fifo_empty=1 -> remain, dat_oe=0, stall=0.
REQ-016 START: one cycle, dat_oe=1, dat_out=0; fifo_data captured into 32-bit shift register at end of this cycle.
REQ-017 DATA: one bit per cycle, MSB (bit 31) first; word counter increments after bit 0.
REQ-018 Prefetch: during the bit-1 cycle of a word that is not the last, if fifo_empty=0, fifo_read=1 and the next word loads at end of the bit-0 cycle, with no gap between words.
REQ-019 If fifo_empty=1 in that bit-1 cycle: after bit 0 enter WAIT; stall=1, dat_oe=1, dat_out held at last data bit, CRC and counters frozen.
REQ-020 WAIT: on first cycle with fifo_empty=0, fifo_read=1 (stall stays 1); next cycle load word, stall=0, return to DATA with bit 31.
REQ-021 fifo_read SHALL never assert while fifo_empty=1, and SHALL assert exactly WORDS times per block.
REQ-022 CRC: CRC16-CCITT (x^16+x^12+x^5+1), initial 16'h0000, updated on every transmitted data bit only (not start, CRC, end, or WAIT cycles).
REQ-023 After bit 0 of word WORDS-1: CRC state, 16 cycles, CRC MSB first, dat_oe=1.
REQ-024 END: one cycle, dat_out=1, dat_oe=1; next cycle IDLE, done=1 for one cycle, busy=0, dat_oe=0.
REQ-025 Without stalls, dat_oe high exactly 1+32*WORDS+16+1 consecutive cycles.
REQ-026 Whenever dat_oe=0, dat_out SHALL be 1.
REQ-027 Word counter width SHALL be ceil(log2(WORDS))+1 bits; no wrap within a block.

Reset
REQ-028 reset=0 sampled at a rising edge SHALL force state IDLE from any state, including mid-DATA/WAIT/CRC.
REQ-029 Reset values: fifo_read=0, dat_out=1, dat_oe=0, busy=0, stall=0, done=0; shift register, CRC, counters cleared.
REQ-030 Reset mid-block SHALL NOT produce done; the aborted block is not resumed.

Verification
REQ-031 Reset: hold reset=0 for 2 cycles from arbitrary state -> all outputs at REQ-029 values next cycle.
REQ-032 WORDS=1, FIFO holds 32'h00000000, pulse start -> one fifo_read; dat_out sequence 0, 32x0, CRC 16'h0000, 1; done one cycle after end bit.
REQ-033 WORDS=2, FIFO holds 32'h0FCBCAFE, 32'h011CAFEF -> second fifo_read in bit-1 cycle of word 0; dat_oe high 82 consecutive cycles; data bits match MSB-first; CRC matches software CRC16-CCITT model.
REQ-034 WORDS=2, FIFO empty at word-0 bit-1 for 5 cycles -> stall=1, dat_out frozen, fifo_read when data arrives, resumes at bit 31; CRC identical to REQ-033.
REQ-035 Assert reset=0 mid-DATA -> REQ-029 values next cycle, no done, no further fifo_read.
REQ-036 Pulse start during CRC state -> ignored; exactly one done; no extra fifo_read.
